aes_cipher_serializer: RTL and testbench
========================================

AES_CIPHER_SERIALIZER -- requirements
Module: aes_cipher_serializer

Interface
REQ-001 SHALL have parameter LATENCY, default 20, giving the cycles from a block applied at the encryption pipeline input (Data_in/key_in) to its ciphertext on cipher_out; legal range 1-63.
REQ-002 SHALL have parameter DEPTH, default 4, giving the number of 128-bit ciphertext FIFO entries; power of two, 2-16.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock, same clock as the encryption pipeline.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 in_valid  input  1  a new block is applied to the pipeline input this cycle.
REQ-007 in_ready  output  1  upstream may assert in_valid this cycle.
REQ-008 cipher_in  input  128  pipeline cipher_out, sampled when the delayed valid matures.
REQ-009 out_valid  output  1  out_data holds a valid word.
REQ-010 out_ready  input  1  downstream accepts the word.
REQ-011 out_data  output  32  ciphertext word.
REQ-012 out_last  output  1  marks the 4th word of a block.
REQ-013 overflow  output  1  sticky flag: a matured block was dropped.

Function
REQ-014 SHALL track each in_valid through a LATENCY-stage valid delay line; stage LATENCY-1 high = "mature" = cipher_in carries that block's ciphertext this cycle.
REQ-015 SHALL keep an in-flight counter: +1 on in_valid, -1 on mature, unchanged if both occur.
REQ-016 in_ready SHALL be high iff in_flight + fifo_count < DEPTH, making overflow impossible when upstream obeys it.
REQ-017 On mature, SHALL write cipher_in into the FIFO tail in the same cycle, unless the FIFO is full and no pop occurs this cycle.
REQ-018 Mature with a full FIFO and no same-cycle pop SHALL drop the block and set overflow, which stays high until rst.
REQ-019 Mature with a full FIFO and a same-cycle pop of the last word SHALL write the block without overflow.
REQ-020 in_valid while in_ready is low SHALL still be tracked; it is not ignored.
REQ-021 Serializer SHALL present the FIFO head as 4 words in the order [127:96], [95:64], [63:32], [31:0]; a 2-bit word index selects the word.
REQ-022 A word SHALL transfer on out_valid && out_ready; the index SHALL increment per transfer and wrap 3->0.
REQ-023 The 3->0 wrap SHALL pop the head entry.
REQ-024 out_last SHALL equal (index==3) && out_valid.
REQ-025 out_valid SHALL be high iff the FIFO is non-empty.
REQ-026 out_data and out_valid SHALL be stable while out_valid && !out_ready.
REQ-027 Read/write pointers SHALL be log2(DEPTH) bits wrapping modulo DEPTH.
REQ-028 fifo_count SHALL be log2(DEPTH)+1 bits; a simultaneous push and pop leaves it unchanged.
REQ-029 Latency from mature to first out_valid SHALL be 1 cycle, since the FIFO write is registered.
REQ-030 in_flight SHALL be 7 bits; it never wraps because in_flight <= LATENCY.

Reset
REQ-031 Asserting rst SHALL asynchronously clear the delay line, in_flight, pointers, fifo_count, word index and overflow.
REQ-032 Outputs during and after reset: out_valid=0, out_last=0, overflow=0, in_ready=1, out_data=0.
REQ-033 rst mid-operation SHALL discard all in-flight and buffered blocks; ciphertexts maturing after release are not captured.
REQ-034 Reset deassertion SHALL take effect at the next rising clk edge.

Verification
REQ-035 Single block: in_valid pulse at cycle 0, cipher_in=00112233_44556677_8899AABB_CCDDEEFF at cycle 19, out_ready=1 -> words 00112233, 44556677, 8899AABB, CCDDEEFF on cycles 20-23; out_last high on cycle 23 only.
REQ-036 Backpressure: out_ready=0 for 10 cycles mid-block -> out_data holds the current word, no word is lost or duplicated, order is preserved.
REQ-037 Credit: in_valid every cycle with out_ready=0 -> in_ready low after 4 issues; exactly 4 blocks are buffered; overflow=0.
REQ-038 Overflow: 5 in_valid pulses ignoring in_ready, out_ready=0 -> overflow=1 at the 5th maturity; the first 4 blocks are delivered intact.
REQ-039 Pop/push collision: FIFO full, last word accepted in the same cycle a block matures -> no overflow; fifo_count stays 4.
REQ-040 Mid-run reset: rst pulse while 3 blocks are in flight and 2 are buffered -> out_valid=0 immediately; no output words after release until new in_valid.

Source files
------------

// File: rtl/aes_cipher_serializer.sv
// rtl/aes_cipher_serializer.sv - tracks AES pipeline blocks, buffers ciphertext, emits 32-bit words
module aes_cipher_serializer #(
  parameter int LATENCY = 20,
  parameter int DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] cipher_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         out_last,
  output logic         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic mature;

  // Stage 0 of the valid delay line is in_valid itself, so only LATENCY-1 flops are needed.
  generate
    if (LATENCY == 1) begin : g_nodly
      assign mature = in_valid;
    end else begin : g_dly
      logic [LATENCY-2:0] dly_q, dly_d;

      always_comb begin
        dly_d    = '0;
        dly_d[0] = in_valid;
        for (int i = 1; i < LATENCY - 1; i++) begin
          dly_d[i] = dly_q[i-1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) dly_q <= '0;
        else     dly_q <= dly_d;
      end

      assign mature = dly_q[LATENCY-2];
    end
  endgenerate

  logic [6:0]    in_flight_q, in_flight_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    idx_q, idx_d;
  logic          overflow_q, overflow_d;
  logic [127:0]  mem_q [DEPTH];

  logic          full, xfer, pop, push;
  logic [7:0]    occupancy;
  logic [127:0]  head;
  logic [31:0]   word;

  always_comb begin
    full      = (count_q == FULL_CNT);
    out_valid = (count_q != '0);
    xfer      = out_valid && out_ready;
    pop       = xfer && (idx_q == 2'd3);
    // A full FIFO still accepts a maturing block when its head leaves this same cycle.
    push      = mature && (!full || pop);

    in_flight_d = in_flight_q;
    case ({in_valid, mature})
      2'b10:   in_flight_d = in_flight_q + 7'd1;
      2'b01:   in_flight_d = in_flight_q - 7'd1;
      default: in_flight_d = in_flight_q;
    endcase

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    idx_d      = xfer ? idx_q + 2'd1    : idx_q;
    overflow_d = overflow_q | (mature && !push);

    occupancy = {1'b0, in_flight_q} + {{(7-AW){1'b0}}, count_q};
    in_ready  = (occupancy < 8'(DEPTH));

    head = mem_q[rd_ptr_q];
    case (idx_q)
      2'd0:    word = head[127:96];
      2'd1:    word = head[95:64];
      2'd2:    word = head[63:32];
      default: word = head[31:0];
    endcase
    out_data = out_valid ? word : 32'd0;
    out_last = out_valid && (idx_q == 2'd3);
    overflow = overflow_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_flight_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      idx_q       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      in_flight_q <= in_flight_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage needs no reset: out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cipher_in;
  end

endmodule

// File: tb/tb_aes_cipher_serializer.sv
// tb/tb_aes_cipher_serializer.sv - scoreboard bench for aes_cipher_serializer
module tb_aes_cipher_serializer;
  localparam int LAT = 20;
  localparam int DEP = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] cipher_in;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic         overflow;

  int           n_vec = 0;
  int           n_err = 0;
  int           cyc = 0;
  logic [127:0] blk;
  logic [127:0] ct_tbl [64];
  logic [32:0]  sb [$];

  always #5 clk = ~clk;

  aes_cipher_serializer #(.LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .cipher_in(cipher_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .overflow(overflow)
  );

  // Stand-in for the encryption pipeline: a block applied in cycle c shows up on cipher_in in cycle c+LAT-1.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid) ct_tbl[(cyc + LAT - 1) % 64] <= blk;
  end
  assign cipher_in = ct_tbl[cyc[5:0]];

  always @(negedge clk) begin
    logic [32:0] exp_w;
    if (!rst && out_valid && out_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        assert (sb.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_word: got %h last %b, want no word", out_data, out_last);
        end
      end else begin
        exp_w = sb.pop_front();
        assert ({out_last, out_data} === exp_w) else begin
          n_err++;
          $error("FAIL word: got last=%b data=%h, want last=%b data=%h",
                 out_last, out_data, exp_w[32], exp_w[31:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_vec++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_blk(input logic [127:0] d);
    sb.push_back({1'b0, d[127:96]});
    sb.push_back({1'b0, d[95:64]});
    sb.push_back({1'b0, d[63:32]});
    sb.push_back({1'b1, d[31:0]});
  endtask

  task automatic drive(input logic [127:0] d, input bit keep);
    in_valid = 1'b1;
    blk      = d;
    if (keep) push_blk(d);
    tick(1);
    in_valid = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drain(input int budget);
    int k;
    k = 0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && k < budget) begin
      tick(1);
      k++;
    end
    check("drain_done", {126'd0, sb.size() == 0, !out_valid}, 128'd3);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    int issued;
    int seen;
    logic [127:0] d;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; blk = '0;
    tick(2);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_overflow", overflow, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_data", out_data, 0);
    rst = 1'b0;
    tick(1);

    // single block, exact timing
    out_ready = 1'b1;
    drive(128'h00112233_44556677_8899AABB_CCDDEEFF, 1);
    tick(18);
    check("t1_c19_valid", out_valid, 0);
    tick(1);
    check("t1_c20_valid", out_valid, 1);
    check("t1_c20_data", out_data, 32'h00112233);
    check("t1_c20_last", out_last, 0);
    tick(3);
    check("t1_c23_data", out_data, 32'hCCDDEEFF);
    check("t1_c23_last", out_last, 1);
    tick(1);
    check("t1_c24_valid", out_valid, 0);
    check("t1_c24_last", out_last, 0);

    // backpressure mid-block
    drive(rnd128(), 1);
    drive(rnd128(), 1);
    tick(19);
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_data", out_data, {96'd0, sb[0][31:0]});
      check("bp_hold_valid", out_valid, 1);
      tick(1);
    end
    drain(80);

    // credit limit
    out_ready = 1'b0;
    issued = 0;
    for (int i = 0; i < 8; i++) begin
      if (in_ready) begin
        drive(rnd128(), 1);
        issued++;
      end else begin
        tick(1);
      end
    end
    check("credit_issued", issued, DEP);
    check("credit_in_ready", in_ready, 0);
    tick(25);
    check("credit_overflow", overflow, 0);
    check("credit_in_ready_full", in_ready, 0);
    check("credit_out_valid", out_valid, 1);
    drain(100);

    // overflow: fifth block dropped
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive(rnd128(), i < 4);
    tick(18);
    check("ovf_before", overflow, 0);
    tick(1);
    check("ovf_set", overflow, 1);
    drain(100);
    check("ovf_sticky", overflow, 1);
    do_reset();
    check("ovf_cleared", overflow, 0);

    // full FIFO: last word popped the cycle a block matures
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive(rnd128(), 1);
    tick(6);
    drive(rnd128(), 1);
    tick(15);
    check("coll_full_in_ready", in_ready, 0);
    out_ready = 1'b1;
    tick(4);
    out_ready = 1'b0;
    check("coll_overflow", overflow, 0);
    check("coll_count4_in_ready", in_ready, 0);
    check("coll_out_valid", out_valid, 1);
    drain(100);

    // reset with blocks both buffered and in flight
    out_ready = 1'b0;
    drive(rnd128(), 1);
    drive(rnd128(), 1);
    tick(3);
    drive(rnd128(), 1);
    drive(rnd128(), 1);
    drive(rnd128(), 1);
    tick(14);
    check("mid_buffered", out_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_in_ready", in_ready, 1);
    sb.delete();
    tick(2);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (out_valid) seen++;
    end
    check("mid_no_output", seen, 0);
    drive(rnd128(), 1);
    drain(60);
    check("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
